rv3_top: RTL and testbench

- Top level of a 3-stage in-order RV32I-subset core: IF -> EX -> WB.
- Contains the PC, a combinational instruction ROM, a datapath instance `dpu` (decode, register file, ALU, branch, data RAM) and WB forwarding.
- Stand-alone: only clock and reset pins; the program is preloaded into the ROM.
- The bench observes state hierarchically: `pc`, and `dpu.rfu.reg_mem[1..3]`.

---
 rtl/rv3_pkg.sv | 58 +++++
 rtl/rv3_datapath.sv | 137 +++++++++++++
 rtl/rv3_regfile.sv | 28 ++
 rtl/rv3_top.sv | 83 ++++++++
 tb/tb_rv3_top.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/rv3_pkg.sv
// Shared definitions for the rv3 core: opcodes, funct fields, ALU ops, NOP, control word.
package rv3_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL     = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SW      = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;
   localparam logic [2:0] F3_BNE     = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
   } alu_op_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    use_imm;
      logic    rf_wr;
      logic    mem_rd;
      logic    mem_wr;
      logic    br_eq;
      logic    br_ne;
      logic    jal;
   } ctrl_t;

   function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         ALU_SUB: r = a - b;
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_SLT: r = {31'b0, $signed(a) < $signed(b)};
         ALU_SLL: r = a << b[4:0];
         ALU_SRL: r = a >> b[4:0];
         default: r = a + b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rv3_datapath.sv
// EX-stage datapath: decode, operand forwarding from WB, ALU, branch resolve, data RAM.
// Result and redirect are combinational from the IF/EX register; the register file is written from WB.
module rv3_datapath
   import rv3_pkg::*;
#(
   parameter int DMEM_DEPTH = 64
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ex_instr,
   input  logic [31:0] ex_pc,
   input  logic        wb_vld,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_dat,
   output logic        ex_wr_vld,
   output logic [4:0]  ex_rd,
   output logic [31:0] ex_res,
   output logic        redir_vld,
   output logic [31:0] redir_pc
);

   localparam int DAW = $clog2(DMEM_DEPTH);

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm;
   logic [31:0] rf_rs1, rf_rs2, op1, op2, alu_res, ld_dat;
   ctrl_t       ctrl;
   logic        br_taken;
   logic [31:0] dmem [DMEM_DEPTH];

   assign opcode = ex_instr[6:0];
   assign ex_rd  = ex_instr[11:7];
   assign f3     = ex_instr[14:12];
   assign rs1    = ex_instr[19:15];
   assign rs2    = ex_instr[24:20];
   assign f7     = ex_instr[31:25];

   assign imm_i = {{20{ex_instr[31]}}, ex_instr[31:20]};
   assign imm_s = {{20{ex_instr[31]}}, ex_instr[31:25], ex_instr[11:7]};
   assign imm_b = {{19{ex_instr[31]}}, ex_instr[31], ex_instr[7], ex_instr[30:25], ex_instr[11:8], 1'b0};
   assign imm_j = {{11{ex_instr[31]}}, ex_instr[31], ex_instr[19:12], ex_instr[20], ex_instr[30:21], 1'b0};

   // Unsupported funct combinations fall through with all enables low, i.e. NOP.
   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      imm         = imm_i;
      case (opcode)
         OPC_OP: begin
            ctrl.rf_wr = 1'b1;
            case (f3)
               F3_ADD_SUB: begin
                  if (f7 == F7_ALT)       ctrl.alu_op = ALU_SUB;
                  else if (f7 != F7_BASE) ctrl.rf_wr  = 1'b0;
               end
               F3_SLL:  begin ctrl.alu_op = ALU_SLL; ctrl.rf_wr = (f7 == F7_BASE); end
               F3_SLT:  begin ctrl.alu_op = ALU_SLT; ctrl.rf_wr = (f7 == F7_BASE); end
               F3_XOR:  begin ctrl.alu_op = ALU_XOR; ctrl.rf_wr = (f7 == F7_BASE); end
               F3_SRL:  begin ctrl.alu_op = ALU_SRL; ctrl.rf_wr = (f7 == F7_BASE); end
               F3_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.rf_wr = (f7 == F7_BASE); end
               F3_AND:  begin ctrl.alu_op = ALU_AND; ctrl.rf_wr = (f7 == F7_BASE); end
               default: ctrl.rf_wr = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            ctrl.rf_wr   = 1'b1;
            ctrl.use_imm = 1'b1;
            case (f3)
               F3_ADD_SUB: ctrl.alu_op = ALU_ADD;
               F3_SLT:     ctrl.alu_op = ALU_SLT;
               F3_XOR:     ctrl.alu_op = ALU_XOR;
               F3_OR:      ctrl.alu_op = ALU_OR;
               F3_AND:     ctrl.alu_op = ALU_AND;
               default:    ctrl.rf_wr  = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            ctrl.use_imm = 1'b1;
            ctrl.rf_wr   = (f3 == F3_LW);
            ctrl.mem_rd  = (f3 == F3_LW);
         end
         OPC_STORE: begin
            ctrl.use_imm = 1'b1;
            ctrl.mem_wr  = (f3 == F3_SW);
            imm          = imm_s;
         end
         OPC_BRANCH: begin
            ctrl.br_eq = (f3 == F3_BEQ);
            ctrl.br_ne = (f3 == F3_BNE);
            imm        = imm_b;
         end
         OPC_JAL: begin
            ctrl.jal   = 1'b1;
            ctrl.rf_wr = 1'b1;
            imm        = imm_j;
         end
         default: ;
      endcase
   end

   rv3_regfile rfu (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1_addr (rs1),
      .rs2_addr (rs2),
      .rs1_dat  (rf_rs1),
      .rs2_dat  (rf_rs2),
      .wr_vld   (wb_vld),
      .wr_addr  (wb_rd),
      .wr_dat   (wb_dat)
   );

   // The WB write lands on the same edge that ends this EX cycle, so bypass it.
   assign op1 = (wb_vld && (wb_rd != 5'd0) && (wb_rd == rs1)) ? wb_dat : rf_rs1;
   assign op2 = (wb_vld && (wb_rd != 5'd0) && (wb_rd == rs2)) ? wb_dat : rf_rs2;

   assign alu_res = alu(ctrl.alu_op, op1, ctrl.use_imm ? imm : op2);
   assign ld_dat  = dmem[alu_res[DAW+1:2]];

   always_ff @(posedge clk) begin
      if (ctrl.mem_wr) dmem[alu_res[DAW+1:2]] <= op2;
   end

   assign br_taken  = (ctrl.br_eq && (op1 == op2)) || (ctrl.br_ne && (op1 != op2));
   assign redir_vld = br_taken || ctrl.jal;
   assign redir_pc  = ex_pc + imm;
   assign ex_wr_vld = ctrl.rf_wr;
   assign ex_res    = ctrl.jal ? (ex_pc + 32'd4) : (ctrl.mem_rd ? ld_dat : alu_res);

   logic unused_addr;
   assign unused_addr = ^{alu_res[31:DAW+2], alu_res[1:0]};

endmodule

// File: rtl/rv3_regfile.sv
// 32x32 register file: two combinational read ports, one write port; x0 hardwired to zero.
module rv3_regfile
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic [31:0] rs1_dat,
   output logic [31:0] rs2_dat,
   input  logic        wr_vld,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_dat
);

   logic [31:0] reg_mem [0:31];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) reg_mem[i] <= '0;
      end else if (wr_vld && (wr_addr != 5'd0)) begin
         reg_mem[wr_addr] <= wr_dat;
      end
   end

   assign rs1_dat = (rs1_addr == 5'd0) ? '0 : reg_mem[rs1_addr];
   assign rs2_dat = (rs2_addr == 5'd0) ? '0 : reg_mem[rs2_addr];

endmodule

// File: rtl/rv3_top.sv
// 3-stage RV32I-subset core (IF -> EX -> WB) with combinational instruction ROM.
// Taken branches/JAL squash the IF instruction (1-cycle bubble); no other stalls.
module rv3_top
   import rv3_pkg::*;
#(
   parameter string       IMEM_FILE  = "prog.hex",
   parameter int          IMEM_DEPTH = 64,
   parameter int          DMEM_DEPTH = 64,
   parameter logic [31:0] RESET_PC   = 32'h0
)
(
   input  logic clk,
   input  logic reset
);

   localparam int IAW = $clog2(IMEM_DEPTH);

   logic [31:0] imem [IMEM_DEPTH];

   logic [31:0] pc, pc_d;
   logic [31:0] ifex_instr_q, ifex_instr_d;
   logic [31:0] ifex_pc_q, ifex_pc_d;
   logic        exwb_vld_q, exwb_vld_d;
   logic [4:0]  exwb_rd_q, exwb_rd_d;
   logic [31:0] exwb_dat_q, exwb_dat_d;

   logic [31:0] if_instr;
   logic        ex_wr_vld, redir_vld;
   logic [4:0]  ex_rd;
   logic [31:0] ex_res, redir_pc;

   // Index truncation makes fetch wrap past the end of the ROM.
   assign if_instr = imem[pc[IAW+1:2]];

   always_comb begin
      pc_d         = pc + 32'd4;
      ifex_instr_d = if_instr;
      ifex_pc_d    = pc;
      if (redir_vld) begin
         pc_d         = redir_pc;
         ifex_instr_d = NOP;
      end
      exwb_vld_d = ex_wr_vld;
      exwb_rd_d  = ex_rd;
      exwb_dat_d = ex_res;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc           <= RESET_PC;
         ifex_instr_q <= NOP;
         ifex_pc_q    <= RESET_PC;
         exwb_vld_q   <= 1'b0;
         exwb_rd_q    <= '0;
         exwb_dat_q   <= '0;
      end else begin
         pc           <= pc_d;
         ifex_instr_q <= ifex_instr_d;
         ifex_pc_q    <= ifex_pc_d;
         exwb_vld_q   <= exwb_vld_d;
         exwb_rd_q    <= exwb_rd_d;
         exwb_dat_q   <= exwb_dat_d;
      end
   end

   rv3_datapath #(
      .DMEM_DEPTH (DMEM_DEPTH)
   ) dpu (
      .clk       (clk),
      .rst_n     (reset),
      .ex_instr  (ifex_instr_q),
      .ex_pc     (ifex_pc_q),
      .wb_vld    (exwb_vld_q),
      .wb_rd     (exwb_rd_q),
      .wb_dat    (exwb_dat_q),
      .ex_wr_vld (ex_wr_vld),
      .ex_rd     (ex_rd),
      .ex_res    (ex_res),
      .redir_vld (redir_vld),
      .redir_pc  (redir_pc)
   );

endmodule

// File: tb/tb_rv3_top.sv
// Program-level bench for rv3_top: table of small programs with expected x1..x3, plus pc-trace and async-reset sequences.
module tb_rv3_top;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic clk;
   logic reset;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [5:0][31:0] prog;
      logic [31:0]      x1;
      logic [31:0]      x2;
      logic [31:0]      x3;
   } vec_t;

   typedef struct packed {
      logic [31:0] x1;
      logic [31:0] x2;
      logic [31:0] x3;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   rv3_top #(.IMEM_FILE("")) dut (
      .clk   (clk),
      .reset (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
                          input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3);
      vec_t v;
      v.prog[0] = w0; v.prog[1] = w1; v.prog[2] = w2;
      v.prog[3] = w3; v.prog[4] = w4; v.prog[5] = w5;
      v.x1 = e1; v.x2 = e2; v.x3 = e3;
      vecs.push_back(v);
   endtask

   // Assert reset, load the ROM, check the held reset state over two edges, release on a falling edge.
   task automatic load_and_release(input vec_t v, input string tag);
      exp_t e;
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 64; i++) dut.imem[i] = (i < 6) ? v.prog[i] : NOP_W;
      check({tag, " rst pc"}, dut.pc, 32'h0);
      check({tag, " rst x1"}, dut.dpu.rfu.reg_mem[1], 32'h0);
      check({tag, " rst x2"}, dut.dpu.rfu.reg_mem[2], 32'h0);
      check({tag, " rst x3"}, dut.dpu.rfu.reg_mem[3], 32'h0);
      @(negedge clk);
      check({tag, " rst held pc"}, dut.pc, 32'h0);
      e.x1 = v.x1; e.x2 = v.x2; e.x3 = v.x3;
      exp_q.push_back(e);
      reset = 1'b1;
   endtask

   task automatic run_and_score(input int cycles, input string tag);
      exp_t e;
      repeat (cycles) @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, " x1"}, dut.dpu.rfu.reg_mem[1], e.x1);
         check({tag, " x2"}, dut.dpu.rfu.reg_mem[2], e.x2);
         check({tag, " x3"}, dut.dpu.rfu.reg_mem[3], e.x3);
      end
   endtask

   initial begin
      reset = 1'b0;

      // addi x1,5; addi x2,10; add x3,x1,x2 (x2 forwarded from WB)
      add_vec(32'h00500093, 32'h00A00113, 32'h002081B3, NOP_W, NOP_W, NOP_W, 32'd5, 32'd10, 32'd15);
      // addi x1,7; sw x1,0(x0); lw x2,0(x0); sub x3,x2,x1
      add_vec(32'h00700093, 32'h00102023, 32'h00002103, 32'h401101B3, NOP_W, NOP_W, 32'd7, 32'd7, 32'd0);
      // addi x1,1; beq x1,x1,+8; addi x2,99 (squashed); addi x3,3
      add_vec(32'h00100093, 32'h00108463, 32'h06300113, 32'h00300193, NOP_W, NOP_W, 32'd1, 32'd0, 32'd3);
      // addi x0,5; add x3,x0,x0; addi x1,-1; slt x2,x1,x0
      add_vec(32'h00500013, 32'h000001B3, 32'hFFF00093, 32'h0000A133, NOP_W, NOP_W, 32'hFFFF_FFFF, 32'd1, 32'd0);
      // addi x1,0xF0; addi x2,4; sll x3,x1,x2; srl x1,x3,x3 (shamt = low 5 bits of 0xF00 = 0)
      add_vec(32'h0F000093, 32'h00400113, 32'h002091B3, 32'h0031D0B3, NOP_W, NOP_W, 32'h0F00, 32'd4, 32'h0F00);
      // addi x1,0x5A; ori x2,x1,0xF0; andi x3,x2,0x3C; xor x1,x1,x3
      add_vec(32'h05A00093, 32'h0F00E113, 32'h03C17193, 32'h0030C0B3, NOP_W, NOP_W, 32'h62, 32'hFA, 32'h38);
      // addi x1,3; bne x1,x1,+8 (not taken); jal x2,+8; addi x3,99 (squashed); addi x3,x3,5
      add_vec(32'h00300093, 32'h00109463, 32'h0080016F, 32'h06300193, 32'h00518193, NOP_W, 32'd3, 32'd12, 32'd5);

      foreach (vecs[k]) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         load_and_release(vecs[k], tag);
         @(posedge clk); #1;
         check({tag, " first fetch pc"}, dut.pc, 32'h4);
         run_and_score(11, tag);
      end

      // Branch pc trace: 4 -> 8 -> (redirect) 12 -> 16
      begin
         logic [31:0] exp_pc [4];
         exp_pc[0] = 32'd4; exp_pc[1] = 32'd8; exp_pc[2] = 32'd12; exp_pc[3] = 32'd16;
         load_and_release(vecs[2], "br");
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("br pc edge%0d", i + 1), dut.pc, exp_pc[i]);
         end
         run_and_score(8, "br");
      end

      // Asynchronous reset mid-program, with a writeback pending in EX/WB.
      load_and_release(vecs[0], "mid");
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("mid async pc", dut.pc, 32'h0);
      check("mid async x1", dut.dpu.rfu.reg_mem[1], 32'h0);
      check("mid async x2", dut.dpu.rfu.reg_mem[2], 32'h0);
      check("mid async x3", dut.dpu.rfu.reg_mem[3], 32'h0);
      @(posedge clk); #1;
      check("mid pending x2 dropped", dut.dpu.rfu.reg_mem[2], 32'h0);
      check("mid held pc", dut.pc, 32'h0);
      void'(exp_q.pop_front());
      load_and_release(vecs[0], "restart");
      run_and_score(12, "restart");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
